ps2_key_event_queue: RTL and testbench
======================================

Name: ps2_key_event_queue

Overview:
- Sits directly downstream of the ps2 receiver and upstream of processor and vga_controller.
- Turns the raw PS/2 set-2 byte stream into decoded key events: prefixes E0 and F0 are folded in, and the Pause (E1) sequence is swallowed.
- Events are buffered in a FIFO that the processor pops with an acknowledge handshake.
- Also emits one-cycle game action strobes (left/right/rotate/soft-drop/hard-drop) for the Tetris datapath.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clock  in  1  system clock (10 MHz PLL output)
- reset  in  1  synchronous, active-high reset
- scan_code  in  8  byte from ps2 receiver
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
- evt_ack  in  1  pop request; ignored when evt_valid=0
- ovf_clear  in  1  clears the sticky overflow flag
- evt_valid  out  1  FIFO non-empty
- evt_data  out  10  head entry: [9]=release, [8]=extended, [7:0]=code
- evt_count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set when an event is dropped
- act_left, act_right, act_rotate, act_soft, act_hard  out  1 each  one-cycle make strobes

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - FIFO emptied; evt_valid=0, evt_data=0, evt_count=0, overflow=0.
  - All act_* = 0; FSM goes to IDLE; skip counter = 0.
  - Reset mid-sequence discards any partial prefix state.
- Decoder FSM. It advances only on cycles with scan_valid=1. States: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE:
    - E0 -> EXT; F0 -> BRK.
    - E1 -> SKIP, skip counter loaded with 7.
    - FA, AA, EE, FE, 00, FF -> IDLE, no event.
    - Any other byte -> emit {0,0,byte}, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift) -> IDLE, no event.
    - E0 -> stay EXT.
    - Any other byte -> emit {0,1,byte}, go IDLE.
  - BRK:
    - E0 -> EXT_BRK.
    - Any other byte -> emit {1,0,byte}, go IDLE.
  - EXT_BRK:
    - 12 or 59 -> IDLE, no event.
    - Any other byte -> emit {1,1,byte}, go IDLE.
  - SKIP:
    - Each byte decrements the counter. When a byte arrives with counter=1, go IDLE.
    - No events are emitted in SKIP.
- Latency: the byte that completes an event is presented at cycle N. The FIFO write commits at the edge ending cycle N, so evt_valid and evt_count reflect it in cycle N+1.
- FIFO:
  - evt_data is the head entry, available the same cycle evt_valid=1. It is 0 when empty.
  - Pop happens on evt_ack && evt_valid.
  - Push and pop in the same cycle: both are performed and count is unchanged.
  - Full: a push with no pop is dropped and overflow is set. A push while full with a simultaneous pop is accepted.
  - Pointers wrap modulo DEPTH.
  - ovf_clear together with a new overflow in the same cycle: set wins.
- Action strobes:
  - Registered; high in cycle N+1 for exactly one cycle, and only for make events (release=0).
  - Mapping:
    - E0 6B -> act_left
    - E0 74 -> act_right
    - E0 75 -> act_rotate
    - E0 72 -> act_soft
    - 29 (space) -> act_hard
  - Strobes fire even if the FIFO is full and the event is dropped.

Optional Feature:
- TYPEMATIC_FILTER_EN.
- Defined:
  - A 5-bit held-key register tracks the five action keys.
  - A make for a key already held suppresses its act_* strobe and does not push to the FIFO.
  - A release clears the held bit and is always pushed.
  - Reset clears all held bits.
- Undefined: every make, including auto-repeat, strobes and pushes.

Test Plan:
- Byte 1C -> in the next cycle evt_valid=1, evt_data=0x01C, evt_count=1, no act_* pulse.
- Bytes E0, F0, 6B -> evt_data=0x36B (release, extended, 6B), act_left stays 0. Bytes E0, 6B -> evt_data=0x16B and a single act_left pulse.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29 -> exactly one event 0x029 and one act_hard pulse; FSM back in IDLE.
- With DEPTH=8, push 9 makes with no ack -> evt_count=8, overflow=1, 9th entry lost. Pulse ovf_clear -> overflow=0. With the FIFO full, a push with concurrent evt_ack -> accepted, count stays 8, head advances.
- Reset asserted after E0, before the next byte; then 75 -> event 0x075 (non-extended), no act_rotate.
- TYPEMATIC_FILTER_EN defined: E0 74 sent three times, then E0 F0 74 -> one act_right pulse, FIFO holds 0x174 then 0x374. Undefined: three pulses, four entries.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan-code decoder with event FIFO and Tetris action strobes.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the action keys.
module ps2_key_event_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    scan_code,
  input  logic          scan_valid,
  input  logic          evt_ack,
  input  logic          ovf_clear,
  output logic          evt_valid,
  output logic [9:0]    evt_data,
  output logic [AW:0]   evt_count,
  output logic          overflow,
  output logic          act_left,
  output logic          act_right,
  output logic          act_rotate,
  output logic          act_soft,
  output logic          act_hard
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_t      state, state_next;
  logic [2:0]  skip_cnt, skip_next;
  logic        emit;
  logic [9:0]  emit_data;
  logic [4:0]  key_sel;
  logic        is_make;
  logic        push_req;
  logic [4:0]  act_next;
  logic        do_push, do_pop, full, drop;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    emit       = 1'b0;
    emit_data  = {2'b00, scan_code};
    if (scan_valid) begin
      case (state)
        IDLE: begin
          case (scan_code)
            8'hE0: state_next = EXT;
            8'hF0: state_next = BRK;
            8'hE1: begin
              state_next = SKIP;
              skip_next  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_next = IDLE;
            default: emit = 1'b1;
          endcase
        end
        EXT: begin
          case (scan_code)
            8'hF0:        state_next = EXT_BRK;
            8'h12, 8'h59: state_next = IDLE;
            8'hE0:        state_next = EXT;
            default: begin
              emit       = 1'b1;
              emit_data  = {2'b01, scan_code};
              state_next = IDLE;
            end
          endcase
        end
        BRK: begin
          if (scan_code == 8'hE0) begin
            state_next = EXT_BRK;
          end else begin
            emit       = 1'b1;
            emit_data  = {2'b10, scan_code};
            state_next = IDLE;
          end
        end
        EXT_BRK: begin
          state_next = IDLE;
          if (scan_code != 8'h12 && scan_code != 8'h59) begin
            emit      = 1'b1;
            emit_data = {2'b11, scan_code};
          end
        end
        SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_next = IDLE;
            skip_next  = 3'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // One-hot action key select, ordered {left, right, rotate, soft, hard}
  always_comb begin
    key_sel = 5'b00000;
    is_make = !emit_data[9];
    if (emit) begin
      key_sel[4] = (emit_data[8:0] == 9'h16B);
      key_sel[3] = (emit_data[8:0] == 9'h174);
      key_sel[2] = (emit_data[8:0] == 9'h175);
      key_sel[1] = (emit_data[8:0] == 9'h172);
      key_sel[0] = (emit_data[8:0] == 9'h029);
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [4:0] held;
  logic       repeat_make;

  always_comb begin
    repeat_make = is_make && |(key_sel & held);
    act_next    = (is_make && !repeat_make) ? key_sel : 5'b00000;
    push_req    = emit && !repeat_make;
  end

  always_ff @(posedge clock) begin
    if (reset)
      held <= 5'b00000;
    else if (is_make)
      held <= held | key_sel;
    else
      held <= held & ~key_sel;
  end
`else
  always_comb begin
    act_next = is_make ? key_sel : 5'b00000;
    push_req = emit;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset)
      {act_left, act_right, act_rotate, act_soft, act_hard} <= 5'b00000;
    else
      {act_left, act_right, act_rotate, act_soft, act_hard} <= act_next;
  end

  // A push into a full FIFO is still accepted when the head is popped the same cycle
  always_comb begin
    full    = (evt_count == FULL_COUNT);
    do_pop  = evt_ack && evt_valid;
    do_push = push_req && (!full || do_pop);
    drop    = push_req && full && !do_pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clear)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= emit_data;
  end

  always_comb begin
    evt_valid = (evt_count != '0);
    evt_data  = evt_valid ? mem[rd_ptr] : 10'h000;
  end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed self-checking bench for ps2_key_event_queue; honours TYPEMATIC_FILTER_EN if defined.
module tb_ps2_key_event_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       evt_ack = 1'b0;
  logic       ovf_clear = 1'b0;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [3:0] evt_count;
  logic       overflow;
  logic       act_left, act_right, act_rotate, act_soft, act_hard;

  int checks = 0;
  int errors = 0;

  ps2_key_event_queue #(.DEPTH(8), .AW(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .evt_ack    (evt_ack),
    .ovf_clear  (ovf_clear),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .act_left   (act_left),
    .act_right  (act_right),
    .act_rotate (act_rotate),
    .act_soft   (act_soft),
    .act_hard   (act_hard)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] acts();
    return {act_left, act_right, act_rotate, act_soft, act_hard};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge; returns at the next falling edge
  task automatic driveCycle(input logic valid, input logic [7:0] code, input logic ack, input logic clr);
    @(negedge clock);
    scan_valid = valid;
    scan_code  = code;
    evt_ack    = ack;
    ovf_clear  = clr;
    @(negedge clock);
    scan_valid = 1'b0;
    evt_ack    = 1'b0;
    ovf_clear  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] code);
    driveCycle(1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic popEvent();
    driveCycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [9:0] drain_exp [8];
    logic [9:0] tm_exp [4];
    int         tm_entries;
    int         right_pulses;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_data", evt_data, 0);
    checkOutput("rst_count", evt_count, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_acts", acts(), 0);

    applyStimulus(8'h1C);
    checkOutput("plain_valid", evt_valid, 1);
    checkOutput("plain_data", evt_data, 10'h01C);
    checkOutput("plain_count", evt_count, 1);
    checkOutput("plain_acts", acts(), 0);
    popEvent();
    checkOutput("pop_count", evt_count, 0);
    checkOutput("pop_data", evt_data, 0);

    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h6B);
    checkOutput("extbrk_data", evt_data, 10'h36B);
    checkOutput("extbrk_acts", acts(), 0);
    popEvent();
    applyStimulus(8'hE0);
    applyStimulus(8'h6B);
    checkOutput("left_data", evt_data, 10'h16B);
    checkOutput("left_pulse", acts(), 5'b10000);
    @(negedge clock);
    checkOutput("left_once", acts(), 0);
    popEvent();

    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("brk_data", evt_data, 10'h21C);
    popEvent();
    applyStimulus(8'hE0);
    applyStimulus(8'h12);
    checkOutput("fakeshift_count", evt_count, 0);
    applyStimulus(8'hAA);
    checkOutput("ack_byte_count", evt_count, 0);

    applyStimulus(8'hE0);
    applyStimulus(8'h72);
    checkOutput("soft_pulse", acts(), 5'b00010);
    popEvent();

    applyStimulus(8'hE1);
    applyStimulus(8'h14);
    applyStimulus(8'h77);
    applyStimulus(8'hE1);
    applyStimulus(8'hF0);
    applyStimulus(8'h14);
    applyStimulus(8'hF0);
    applyStimulus(8'h77);
    checkOutput("pause_count", evt_count, 0);
    applyStimulus(8'h29);
    checkOutput("hard_count", evt_count, 1);
    checkOutput("hard_data", evt_data, 10'h029);
    checkOutput("hard_pulse", acts(), 5'b00001);
    @(negedge clock);
    checkOutput("hard_once", acts(), 0);
    popEvent();
    applyStimulus(8'h1C);
    checkOutput("post_pause_idle", evt_data, 10'h01C);
    popEvent();

    for (int i = 0; i < 9; i++) applyStimulus(8'h30 + 8'(i));
    checkOutput("full_count", evt_count, 8);
    checkOutput("full_ovf", overflow, 1);
    checkOutput("full_head", evt_data, 10'h030);
    driveCycle(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_cleared", overflow, 0);
    driveCycle(1'b1, 8'h39, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", overflow, 1);
    checkOutput("ovf_set_count", evt_count, 8);
    driveCycle(1'b0, 8'h00, 1'b0, 1'b1);
    driveCycle(1'b1, 8'h40, 1'b1, 1'b0);
    checkOutput("full_pushpop_count", evt_count, 8);
    checkOutput("full_pushpop_head", evt_data, 10'h031);
    checkOutput("full_pushpop_ovf", overflow, 0);
    drain_exp = '{10'h031, 10'h032, 10'h033, 10'h034, 10'h035, 10'h036, 10'h037, 10'h040};
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain_%0d", i), evt_data, drain_exp[i]);
      popEvent();
    end
    checkOutput("drained_count", evt_count, 0);

    applyStimulus(8'hE0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'h75);
    checkOutput("midreset_data", evt_data, 10'h075);
    checkOutput("midreset_acts", acts(), 0);
    popEvent();

    right_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hE0);
      applyStimulus(8'h74);
      if (act_right) right_pulses++;
    end
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h74);
    checkOutput("release_right_acts", acts(), 0);
`ifdef TYPEMATIC_FILTER_EN
    checkOutput("tm_pulses", right_pulses, 1);
    tm_entries = 2;
    tm_exp = '{10'h174, 10'h374, 10'h000, 10'h000};
`else
    checkOutput("tm_pulses", right_pulses, 3);
    tm_entries = 4;
    tm_exp = '{10'h174, 10'h174, 10'h174, 10'h374};
`endif
    checkOutput("tm_count", evt_count, tm_entries);
    for (int i = 0; i < tm_entries; i++) begin
      checkOutput($sformatf("tm_entry_%0d", i), evt_data, tm_exp[i]);
      popEvent();
    end
    checkOutput("tm_empty", evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
